// File: rtl/exec_pkg.sv
// Shared types and helpers for the two-stage execute/AGU pipe.
// Op encoding, alignment width and offset sign-extension.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLTU  = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_t;

  localparam int SEXT_MAXW = 128;
  typedef logic [SEXT_MAXW-1:0] sext_t;

  function automatic int ALIGN_LSB(input int width);
    return $clog2(width / 8);
  endfunction

  // Sign-extend the low w bits of v across the full helper width.
  function automatic sext_t sext(input sext_t v, input int w);
    sext_t m;
    logic  s;
    m = (sext_t'(1) << w) - sext_t'(1);
    s = |(v & (sext_t'(1) << (w - 1)));
    return s ? (v | ~m) : (v & m);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the S2 stage of exec_agu_pipe.
// Produces result, zero and signed-overflow flags.
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int M = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        res_o = sum;
        ovf_o = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
      end
      ALU_SUB: begin
        res_o = diff;
        ovf_o = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
      end
      ALU_AND:   res_o = a_i & b_i;
      ALU_OR:    res_o = a_i | b_i;
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_SLT:   res_o = WIDTH'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  res_o = WIDTH'(a_i < b_i);
      ALU_PASSB: res_o = b_i;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/exec_agu_pipe.sv
// Two-stage execute/AGU pipe with valid/ready on both sides.
// Define AGU_ALIGN_CHECK_EN to register a memory-mode misalign flag.
module exec_agu_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int OFFSET_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_mem,
  input  logic [2:0]          alu_op,
  input  logic [WIDTH-1:0]    din_a,
  input  logic [WIDTH-1:0]    din_b,
  input  logic [OFFSET_W-1:0] offset,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    dout,
  output logic                zero,
  output logic                ovf,
  output logic                misalign
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  alu_op_t          s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_ovf;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;
  assign off_ext  = WIDTH'(sext(SEXT_MAXW'(offset), OFFSET_W));

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .op_i   (s1_op_q),
    .res_o  (alu_res),
    .zero_o (alu_zero),
    .ovf_o  (alu_ovf)
  );

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_load);
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
    dout_d     = dout_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    if (accept) begin
      s1_a_d  = op_mem ? din_b : din_a;
      s1_b_d  = op_mem ? off_ext : din_b;
      s1_op_d = op_mem ? ALU_ADD : alu_op_t'(alu_op);
    end
    if (s2_load) begin
      dout_d = alu_res;
      zero_d = alu_zero;
      ovf_d  = alu_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= ALU_ADD;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef AGU_ALIGN_CHECK_EN
  localparam int AL = ALIGN_LSB(WIDTH);

  logic s1_mem_q, s1_mem_d;
  logic mis_q, mis_d;

  always_comb begin
    s1_mem_d = s1_mem_q;
    mis_d    = mis_q;
    if (accept)  s1_mem_d = op_mem;
    if (s2_load) mis_d = s1_mem_q & (|alu_res[AL-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mem_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      s1_mem_q <= s1_mem_d;
      mis_q    <= mis_d;
    end
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  assign out_valid = s2_valid_q;
  assign dout      = dout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_exec_agu_pipe.sv
// Bench for exec_agu_pipe: directed cases plus random stream
// checked against an arithmetic reference model and scoreboard.
module tb_exec_agu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op_mem, out_valid, out_ready;
  logic [2:0]  alu_op;
  logic [63:0] din_a, din_b, dout;
  logic [11:0] offset;
  logic        zero, ovf, misalign;

  logic        v_in_valid, v_in_ready, v_op_mem, v_out_valid, v_out_ready;
  logic [2:0]  v_alu_op;
  logic [15:0] v_din_a, v_din_b, v_dout;
  logic [7:0]  v_offset;
  logic        v_zero, v_ovf, v_misalign;

  always #5 clk = ~clk;

  exec_agu_pipe #(.WIDTH(64), .OFFSET_W(12)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_mem(op_mem), .alu_op(alu_op),
    .din_a(din_a), .din_b(din_b), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .zero(zero), .ovf(ovf), .misalign(misalign)
  );

  exec_agu_pipe #(.WIDTH(16), .OFFSET_W(8)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(v_in_valid), .in_ready(v_in_ready),
    .op_mem(v_op_mem), .alu_op(v_alu_op),
    .din_a(v_din_a), .din_b(v_din_b), .offset(v_offset),
    .out_valid(v_out_valid), .out_ready(v_out_ready),
    .dout(v_dout), .zero(v_zero), .ovf(v_ovf), .misalign(v_misalign)
  );

  typedef struct {
    logic [63:0] d;
    logic        z;
    logic        o;
    logic        m;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_drain = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit mem, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [11:0] off);
    exp_t e;
    logic [63:0] x, y;
    logic [2:0]  o;
    int          so;
    logic signed [64:0] s;
    logic signed [64:0] maxv, minv;
    maxv = 65'sd9223372036854775807;
    minv = -maxv - 65'sd1;
    so   = int'($signed(off));
    if (mem) begin
      x = b; y = 64'(longint'(so)); o = 3'd0;
    end else begin
      x = a; y = b; o = op;
    end
    e.o = 1'b0;
    case (o)
      3'd0: begin
        e.d = x + y;
        s = $signed({x[63], x}) + $signed({y[63], y});
        e.o = (s > maxv) || (s < minv);
      end
      3'd1: begin
        e.d = x - y;
        s = $signed({x[63], x}) - $signed({y[63], y});
        e.o = (s > maxv) || (s < minv);
      end
      3'd2: e.d = x & y;
      3'd3: e.d = x | y;
      3'd4: e.d = x ^ y;
      3'd5: e.d = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      3'd6: e.d = (x < y) ? 64'd1 : 64'd0;
      default: e.d = y;
    endcase
    e.z = (e.d == 64'd0);
`ifdef AGU_ALIGN_CHECK_EN
    e.m = mem && ((e.d % 64'd8) != 64'd0);
`else
    e.m = 1'b0;
`endif
    return e;
  endfunction

  task automatic put(input bit mem, input logic [2:0] op,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [11:0] off);
    in_valid = 1'b1;
    op_mem   = mem;
    alu_op   = op;
    din_a    = a;
    din_b    = b;
    offset   = off;
  endtask

  task automatic step();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%0d expected=>0", sb.size());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_dout", dout, e.d);
        chkb("sb_zero", zero, e.z);
        chkb("sb_ovf", ovf, e.o);
        chkb("sb_mis", misalign, e.m);
      end
      n_drain++;
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(op_mem, alu_op, din_a, din_b, offset));
      n_acc++;
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   k, acc0, drn0, cyc, guard;
    logic exp_mis;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    op_mem = 1'b0; alu_op = 3'd0;
    din_a = '0; din_b = '0; offset = '0;
    v_in_valid = 1'b0; v_out_ready = 1'b0;
    v_op_mem = 1'b0; v_alu_op = 3'd0;
    v_din_a = '0; v_din_b = '0; v_offset = '0;
    #12;
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout, 64'h0);
    chkb("rst_zero", zero, 1'b0);
    chkb("rst_ovf", ovf, 1'b0);
    chkb("rst_mis", misalign, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chkb("post_rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    put(0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 12'h0);
    step();
    in_valid = 1'b0;
    chkb("add_lat1_valid", out_valid, 1'b0);
    step();
    chkb("add_lat2_valid", out_valid, 1'b1);
    chk("add_dout", dout, 64'h8000_0000_0000_0000);
    chkb("add_ovf", ovf, 1'b1);
    chkb("add_zero", zero, 1'b0);
    step();

    put(0, 3'd1, 64'd5, 64'd5, 12'h0);
    step();
    in_valid = 1'b0;
    step();
    chk("sub_dout", dout, 64'h0);
    chkb("sub_zero", zero, 1'b1);
    chkb("sub_ovf", ovf, 1'b0);
    step();

    put(0, 3'd5, '1, 64'd1, 12'h0);
    step();
    put(0, 3'd6, '1, 64'd1, 12'h0);
    step();
    in_valid = 1'b0;
    chk("slt_dout", dout, 64'd1);
    step();
    chk("sltu_dout", dout, 64'd0);
    step();

    put(1, 3'd5, 64'hDEAD, 64'h1000, 12'hFFC);
    step();
    put(1, 3'd3, 64'hBEEF, 64'h1000, 12'd8);
    step();
    in_valid = 1'b0;
`ifdef AGU_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    chk("mem_neg_dout", dout, 64'h0FFC);
    chkb("mem_neg_mis", misalign, exp_mis);
    step();
    chk("mem_pos_dout", dout, 64'h1008);
    chkb("mem_pos_mis", misalign, 1'b0);
    step();

    // Back-pressure: beats 1..6 carry dout == k.
    out_ready = 1'b0;
    acc0 = n_acc;
    drn0 = n_drain;
    k = 1;
    for (int t = 0; t < 6; t++) begin
      put(0, 3'd0, 64'(k), 64'd0, 12'h0);
      step();
      if (last_acc) k++;
    end
    chk("bp_accepted", 64'(n_acc - acc0), 64'd2);
    chkb("bp_in_ready", in_ready, 1'b0);
    chk("bp_dout_hold", dout, 64'd1);
    out_ready = 1'b1;
    guard = 0;
    while ((n_drain - drn0) < 6 && guard < 30) begin
      if (k <= 6) put(0, 3'd0, 64'(k), 64'd0, 12'h0);
      else in_valid = 1'b0;
      step();
      if (last_acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_drained", 64'(n_drain - drn0), 64'd6);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Full throughput with random beats.
    drn0 = n_drain;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      put(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          {$urandom(), $urandom()}, {$urandom(), $urandom()},
          12'($urandom()));
      step();
      cyc++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      step();
      cyc++;
      guard++;
    end
    chk("tp_outputs", 64'(n_drain - drn0), 64'd100);
    chk("tp_cycles", 64'(cyc), 64'd102);

    // Reset while two beats are stalled.
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      put(0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 12'h0);
      step();
    end
    chkb("stall_full_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chkb("arst_out_valid", out_valid, 1'b0);
    chk("arst_dout", dout, 64'h0);
    chkb("arst_zero", zero, 1'b0);
    chkb("arst_ovf", ovf, 1'b0);
    chkb("arst_mis", misalign, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chkb("arst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    put(0, 3'd2, 64'hF0, 64'h3C, 12'h0);
    step();
    in_valid = 1'b0;
    chkb("arst_lat1_valid", out_valid, 1'b0);
    step();
    chkb("arst_lat2_valid", out_valid, 1'b1);
    chk("arst_new_dout", dout, 64'h30);
    step();

    // Narrow instance: wrap in memory mode.
    v_out_ready = 1'b1;
    v_in_valid  = 1'b1;
    v_op_mem    = 1'b1;
    v_alu_op    = 3'd7;
    v_din_a     = 16'h1234;
    v_din_b     = 16'hFFFE;
    v_offset    = 8'd4;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
    @(posedge clk); #1;
    chkb("w16_valid", v_out_valid, 1'b1);
    chk("w16_dout", {48'h0, v_dout}, 64'h2);
    chkb("w16_ovf", v_ovf, 1'b0);
    chkb("w16_zero", v_zero, 1'b0);
    chkb("w16_mis", v_misalign, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
